// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared definitions for the axis_FIR sample sequencer.
//   - State encoding (also visible on the sequencer's 2-bit state output).
//   - Default strobe-divider width.
//   - FIR_PIPE_LAT: axis_FIR register latency in strobes (data_in stage + buffer stage).
package fir_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_FILL  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam int unsigned DEFAULT_DIV_WIDTH = 16;
    localparam int unsigned FIR_PIPE_LAT      = 2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StFlush = ST_FLUSH,
        StFill  = ST_FILL,
        StRun   = ST_RUN
    } fir_seq_state_e;

endpackage

// File: rtl/axis_fir_sequencer_if.sv
// axis_fir_sequencer_if: FIR-facing stream/strobe signals of the sequencer.
//   s_valid    upstream stream valid (source -> sequencer)
//   next_dv    one-cycle FIR sample strobe
//   fir_tvalid FIR S_AXIS_tvalid
//   out_valid  FIR output is meaningful (level)
//   out_tick   pulse the cycle after each RUN-state strobe
// master: the sequencer side; slave: the surrounding logic.
interface axis_fir_sequencer_if;

    logic s_valid;
    logic next_dv;
    logic fir_tvalid;
    logic out_valid;
    logic out_tick;

    modport master (
        input  s_valid,
        output next_dv,
        output fir_tvalid,
        output out_valid,
        output out_tick
    );

    modport slave (
        output s_valid,
        input  next_dv,
        input  fir_tvalid,
        input  out_valid,
        input  out_tick
    );

endinterface

// File: rtl/fir_strobe_div.sv
// fir_strobe_div: programmable clock divider producing the FIR sample strobe.
//   clk, reset  clock and synchronous active-high reset
//   run         next cycle is an active (non-IDLE) cycle
//   clear       restart the count at 0 on the next cycle
//   div         clocks per strobe for the next cycle (must be >= 1)
//   next_dv     registered strobe, high for the cycle in which the count is div-1
module fir_strobe_div #(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 next_dv
);

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] div_last;
    logic                 next_dv_q, next_dv_d;

    // The strobe is decoded from the next count so that it lines up with the
    // count register while still coming straight out of a flop.
    always_comb begin
        div_last  = div - DIV_WIDTH'(1);
        div_cnt_d = '0;
        if (run && !clear && (div_cnt_q != div_last)) begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
        end
        next_dv_d = run && (div_cnt_d == div_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q <= '0;
            next_dv_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            next_dv_q <= next_dv_d;
        end
    end

    assign next_dv = next_dv_q;

endmodule

// File: rtl/axis_fir_sequencer.sv
// axis_fir_sequencer: FLUSH/FILL/RUN sequencer for a boxcar-decimating axis_FIR.
//   a_clk, reset  clock and synchronous active-high reset
//   enable        1 runs the sequencer, 0 returns it to IDLE
//   cfg_div       clocks per FIR strobe (0 is treated as 1)
//   cfg_load      pulse: latch cfg_div and restart from FLUSH
//   fir           FIR-facing stream/strobe signals (master modport)
//   strobe_count  RUN-state strobe count, wraps
//   state         0 IDLE, 1 FLUSH, 2 FILL, 3 RUN
// All outputs are registered.
module axis_fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned FIR_DECI   = 64,
    parameter int unsigned FIR_DECI_L = 6,
    parameter int unsigned DIV_WIDTH  = DEFAULT_DIV_WIDTH,
    parameter int unsigned PIPE_LAT   = FIR_PIPE_LAT
) (
    input  logic                  a_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  cfg_div,
    input  logic                  cfg_load,
    axis_fir_sequencer_if.master  fir,
    output logic [31:0]           strobe_count,
    output logic [1:0]            state
);

    localparam int unsigned PhW = FIR_DECI_L + 1;
    localparam logic [PhW-1:0] FlushLast = PhW'(FIR_DECI - 1);
    localparam logic [PhW-1:0] FlushDone = PhW'(FIR_DECI);
    localparam logic [PhW-1:0] FillLast  = PhW'(FIR_DECI + PIPE_LAT - 1);
    localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);

    fir_seq_state_e       state_q, state_d;
    logic [PhW-1:0]       phase_q, phase_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [31:0]          strobe_count_q;
    logic                 out_tick_q, out_valid_q, fir_tvalid_q;
    logic                 restart;
    logic                 count_strobe;
    logic                 strobe;

    fir_strobe_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_strobe_div (
        .clk     (a_clk),
        .reset   (reset),
        .run     (state_d != StIdle),
        .clear   (restart),
        .div     (div_d),
        .next_dv (strobe)
    );

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        div_d        = div_q;
        restart      = 1'b0;
        count_strobe = 1'b0;

        if (cfg_load || (state_q == StIdle && enable)) begin
            div_d = (cfg_div == '0) ? DivOne : cfg_div;
        end

        if (!enable) begin
            state_d = StIdle;
            phase_d = '0;
        end else if (state_q == StIdle) begin
            state_d = StFlush;
            restart = 1'b1;
            phase_d = '0;
        end else if (cfg_load || (!fir.s_valid && (state_q inside {StFill, StRun}))) begin
            state_d = StFlush;
            restart = 1'b1;
            phase_d = '0;
        end else begin
            unique case (state_q)
                StFlush: begin
                    // Taps are all zero once FlushDone is reached; keep
                    // strobing (uncounted) until the source has data.
                    if (phase_q == FlushDone) begin
                        if (fir.s_valid) begin
                            state_d = StFill;
                            phase_d = '0;
                        end
                    end else if (strobe) begin
                        if (phase_q == FlushLast && fir.s_valid) begin
                            state_d = StFill;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + PhW'(1);
                        end
                    end
                end
                StFill: begin
                    if (strobe) begin
                        if (phase_q == FillLast) begin
                            state_d = StRun;
                            phase_d = '0;
                        end else begin
                            phase_d = phase_q + PhW'(1);
                        end
                    end
                end
                StRun:   count_strobe = strobe;
                default: ;
            endcase
        end
    end

    always_ff @(posedge a_clk) begin
        if (reset) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            div_q          <= DivOne;
            strobe_count_q <= '0;
            out_tick_q     <= 1'b0;
            out_valid_q    <= 1'b0;
            fir_tvalid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            div_q          <= div_d;
            strobe_count_q <= count_strobe ? strobe_count_q + 32'd1 : strobe_count_q;
            out_tick_q     <= count_strobe;
            out_valid_q    <= (state_d == StRun);
            fir_tvalid_q   <= (state_d inside {StFill, StRun}) && fir.s_valid;
        end
    end

    assign fir.next_dv    = strobe;
    assign fir.fir_tvalid = fir_tvalid_q;
    assign fir.out_valid  = out_valid_q;
    assign fir.out_tick   = out_tick_q;
    assign strobe_count   = strobe_count_q;
    assign state          = state_q;

endmodule

// File: doc/axis_fir_sequencer.md
Name: axis_fir_sequencer

Overview:
- Controls one axis_FIR-style boxcar decimator (FIR_DECI taps, sample strobe input next_dv).
- Generates the FIR sample strobe at a programmable clock divider and gates the FIR's tvalid.
- Sequences FLUSH, FILL and RUN, so downstream logic only sees FIR output once the tap buffer holds FIR_DECI real samples.
- Sits between the upstream ADC/stream source and the FIR; drives the FIR's next_dv and S_AXIS_tvalid.

Parameters:
- FIR_DECI, 64, FIR length in strobes; must be a power of two.
- FIR_DECI_L, 6, log2(FIR_DECI); width of the tap/flush counters.
- DIV_WIDTH, 16, width of the strobe divider setting.
- PIPE_LAT, 2, FIR register latency in strobes (data_in stage plus buffer stage).

Ports:
- a_clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 runs the sequencer, 0 returns it to IDLE.
- cfg_div  in  DIV_WIDTH  clocks per strobe; 0 is treated as 1.
- cfg_load  in  1  one-cycle pulse; latches cfg_div and restarts the sequence.
- s_valid  in  1  upstream stream valid.
- next_dv  out  1  one-cycle FIR sample strobe.
- fir_tvalid  out  1  drives the FIR's S_AXIS_tvalid.
- out_valid  out  1  level; FIR output is meaningful.
- out_tick  out  1  one-cycle pulse the cycle after each RUN-state strobe.
- strobe_count  out  32  RUN-state strobe count; wraps.
- state  out  2  0 IDLE, 1 FLUSH, 2 FILL, 3 RUN.

Behaviour:
- Reset values:
  - state = IDLE.
  - next_dv, fir_tvalid, out_valid and out_tick = 0.
  - Divider counter, phase counter and strobe_count = 0.
  - Latched div = 1.
- Divider:
  - div_cnt counts 0..div-1 in every state except IDLE.
  - next_dv = 1 for exactly the cycle div_cnt == div-1; div_cnt then returns to 0.
  - div = 1 gives a strobe every clock.
  - On entering FLUSH, div_cnt clears, so the first strobe comes div clocks after entry.
- IDLE:
  - No strobes; fir_tvalid = 0.
  - enable = 1 latches cfg_div (0 becomes 1), then enters FLUSH next cycle.
- FLUSH:
  - fir_tvalid = 0, so the FIR writes zeros into its taps and clears its sum.
  - Counts FIR_DECI strobes; the cycle after the FIR_DECI-th strobe, enters FILL if s_valid = 1, otherwise stays in FLUSH, continuing to strobe without counting.
- FILL:
  - fir_tvalid = s_valid.
  - Counts FIR_DECI+PIPE_LAT strobes; the cycle after the last one, enters RUN.
- RUN:
  - fir_tvalid = s_valid; out_valid = 1.
  - Each strobe increments strobe_count and produces out_tick on the following cycle.
- Restart conditions:
  - s_valid = 0 in FILL or RUN: next cycle enters FLUSH, out_valid drops, and the phase counter and div_cnt clear.
  - cfg_load in FLUSH, FILL or RUN: latches cfg_div and enters FLUSH (re-entering FLUSH restarts its count).
  - cfg_load in IDLE: latches cfg_div only.
- enable = 0 in any state:
  - IDLE on the next cycle; next_dv, fir_tvalid, out_valid and out_tick go to 0 that same cycle.
  - strobe_count holds its value.
- Priorities for simultaneous events: reset > enable low > cfg_load > s_valid low > normal transition.
- Reset mid-operation: every register returns to its reset value on the next edge. An out_tick already pending is dropped.
- Arithmetic:
  - Phase counter is FIR_DECI_L+1 bits wide, enough for FIR_DECI+PIPE_LAT.
  - div_cnt compares at DIV_WIDTH bits, unsigned.
  - strobe_count wraps from 0xFFFFFFFF to 0.
- Outputs are all registered; no combinational path from any input to any output.

Decomposition:
- Shared package fir_seq_pkg holds:
  - State encoding constants ST_IDLE = 0, ST_FLUSH = 1, ST_FILL = 2, ST_RUN = 3.
  - Default DIV_WIDTH.
  - The PIPE_LAT constant, shared with axis_FIR users.
- One natural sub-module, fir_strobe_div: divider counter with a clear input, a div input and the registered next_dv output.
- FSM and counters remain in the top module.

Test Plan:
- Reset, then enable = 1, cfg_div = 4, s_valid = 1 (FIR_DECI = 64, PIPE_LAT = 2):
  - First next_dv 4 clocks after FLUSH entry.
  - FILL after 64 strobes.
  - RUN after a further 66 strobes, i.e. 130 strobes = 520 clocks.
  - out_valid rises then; out_tick follows each strobe by 1 clock.
- cfg_div = 0 or 1: next_dv high every clock in FLUSH, FILL and RUN; RUN reached 130 clocks after FLUSH entry.
- In RUN, drop s_valid for 1 clock:
  - Next cycle state = FLUSH, out_valid = 0.
  - Re-enters RUN only after a full 64 + 66 strobe sequence with s_valid high again.
- cfg_load with cfg_div = 8 while in FILL at strobe 30:
  - Returns to FLUSH with strobes every 8 clocks.
  - Same cycle as enable = 0: IDLE wins and no further strobes are issued.
- Preload strobe_count to 0xFFFFFFFE (force), then run 3 RUN strobes: strobe_count reads 0xFFFFFFFF, then 0, then 1.
- Assert reset mid-RUN coincident with a strobe:
  - All outputs 0 on the next edge and no out_tick.
  - With enable still high, FLUSH restarts cleanly after reset deasserts.
